// File: rtl/qracc_tile_sequencer.sv
// qracc_tile_sequencer: autonomous layer-pass engine driving buffer reads,
// feature-loader staging, one seq_acc MAC and one write-back per pixel.
module qracc_tile_sequencer #(
  parameter int unsigned addrWidth  = 32,
  parameter int unsigned countWidth = 16,
  parameter int unsigned wordBytes  = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic [addrWidth-1:0]  cfg_rd_base_i,
  input  logic [addrWidth-1:0]  cfg_wr_base_i,
  input  logic [addrWidth-1:0]  cfg_rd_stride_i,
  input  logic [addrWidth-1:0]  cfg_wr_stride_i,
  input  logic [countWidth-1:0] cfg_words_i,
  input  logic [countWidth-1:0] cfg_num_pixels_i,
  output logic                  buf_rd_en_o,
  output logic [addrWidth-1:0]  buf_rd_addr_o,
  output logic                  fl_wr_en_o,
  output logic [addrWidth-1:0]  fl_addr_o,
  output logic                  mac_valid_o,
  input  logic                  qracc_ready_i,
  input  logic                  qracc_valid_i,
  output logic                  wb_en_o,
  output logic [addrWidth-1:0]  wb_addr_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [countWidth-1:0] pixel_o
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DRAIN, MAC_REQ, MAC_WAIT, WB, DONE
  } state_t;

  localparam logic [addrWidth-1:0]  STEP = addrWidth'(wordBytes);
  localparam logic [countWidth-1:0] ONE  = countWidth'(1);

  state_t state, state_nx;

  logic [countWidth-1:0] words_q, npix_q;
  logic [countWidth-1:0] pixel_q, word_q, fl_idx_q;
  logic [addrWidth-1:0]  rd_stride_q, wr_stride_q;
  logic [addrWidth-1:0]  pix_rd_q, rd_addr_q, wr_addr_q;
  logic                  fl_wr_q;
  logic                  last_word, last_pix;
  logic [addrWidth-1:0]  pix_rd_nx;

  assign last_word = (word_q == words_q - ONE);
  assign last_pix  = (pixel_q == npix_q - ONE);
  assign pix_rd_nx = pix_rd_q + rd_stride_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear_i) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (start_i)
            state_nx = (cfg_num_pixels_i == '0) ? DONE : FETCH;
        FETCH:    if (last_word) state_nx = DRAIN;
        DRAIN:    state_nx = MAC_REQ;
        MAC_REQ:  if (qracc_ready_i) state_nx = MAC_WAIT;
        MAC_WAIT: if (qracc_valid_i) state_nx = WB;
        WB:       state_nx = last_pix ? DONE : FETCH;
        DONE:     state_nx = IDLE;
        default:  state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      words_q     <= '0;
      npix_q      <= '0;
      pixel_q     <= '0;
      word_q      <= '0;
      fl_idx_q    <= '0;
      rd_stride_q <= '0;
      wr_stride_q <= '0;
      pix_rd_q    <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      fl_wr_q     <= 1'b0;
    end else begin
      // loader write trails the read by the buffer's 1-cycle latency
      fl_wr_q  <= (state == FETCH) && !clear_i;
      fl_idx_q <= word_q;
      if (clear_i) begin
        pixel_q <= '0;
        word_q  <= '0;
      end else if (state == IDLE && start_i) begin
        words_q     <= (cfg_words_i == '0) ? ONE : cfg_words_i;
        npix_q      <= cfg_num_pixels_i;
        rd_stride_q <= cfg_rd_stride_i;
        wr_stride_q <= cfg_wr_stride_i;
        pix_rd_q    <= cfg_rd_base_i;
        rd_addr_q   <= cfg_rd_base_i;
        wr_addr_q   <= cfg_wr_base_i;
        pixel_q     <= '0;
        word_q      <= '0;
      end else if (state == FETCH) begin
        word_q    <= word_q + ONE;
        rd_addr_q <= rd_addr_q + STEP;
      end else if (state == WB && !last_pix) begin
        pixel_q   <= pixel_q + ONE;
        word_q    <= '0;
        pix_rd_q  <= pix_rd_nx;
        rd_addr_q <= pix_rd_nx;
        wr_addr_q <= wr_addr_q + wr_stride_q;
      end
    end
  end

  assign buf_rd_en_o   = (state == FETCH);
  assign buf_rd_addr_o = buf_rd_en_o ? rd_addr_q : '0;
  assign fl_wr_en_o    = fl_wr_q;
  assign fl_addr_o     = fl_wr_q ? addrWidth'(fl_idx_q) : '0;
  assign mac_valid_o   = (state == MAC_REQ);
  assign wb_en_o       = (state == WB);
  assign wb_addr_o     = wb_en_o ? wr_addr_q : '0;
  assign busy_o        = (state != IDLE);
  assign done_o        = (state == DONE);
  assign pixel_o       = pixel_q;

endmodule

// File: tb/tb_qracc_tile_sequencer.sv
// tb_qracc_tile_sequencer: scoreboard bench with a seq_acc latency and
// backpressure model; expected strobes are queued with their cycle offsets.
module tb_qracc_tile_sequencer;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start_i = 1'b0;
  logic        clear_i = 1'b0;
  logic [31:0] cfg_rd_base_i = '0;
  logic [31:0] cfg_wr_base_i = '0;
  logic [31:0] cfg_rd_stride_i = '0;
  logic [31:0] cfg_wr_stride_i = '0;
  logic [15:0] cfg_words_i = '0;
  logic [15:0] cfg_num_pixels_i = '0;
  logic        buf_rd_en_o;
  logic [31:0] buf_rd_addr_o;
  logic        fl_wr_en_o;
  logic [31:0] fl_addr_o;
  logic        mac_valid_o;
  logic        qracc_ready_i;
  logic        qracc_valid_i;
  logic        wb_en_o;
  logic [31:0] wb_addr_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] pixel_o;

  qracc_tile_sequencer dut (
    .clk(clk), .nrst(nrst),
    .start_i(start_i), .clear_i(clear_i),
    .cfg_rd_base_i(cfg_rd_base_i), .cfg_wr_base_i(cfg_wr_base_i),
    .cfg_rd_stride_i(cfg_rd_stride_i), .cfg_wr_stride_i(cfg_wr_stride_i),
    .cfg_words_i(cfg_words_i), .cfg_num_pixels_i(cfg_num_pixels_i),
    .buf_rd_en_o(buf_rd_en_o), .buf_rd_addr_o(buf_rd_addr_o),
    .fl_wr_en_o(fl_wr_en_o), .fl_addr_o(fl_addr_o),
    .mac_valid_o(mac_valid_o), .qracc_ready_i(qracc_ready_i),
    .qracc_valid_i(qracc_valid_i),
    .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o),
    .busy_o(busy_o), .done_o(done_o), .pixel_o(pixel_o)
  );

  always #5 clk = ~clk;

  int cnt = 0;
  int start_cnt = 0;
  int lat = 4;
  int bp_len = 0;
  int lat_cnt = 0;
  int bp_seen = 0;
  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  ev_t rd_q[$], fl_q[$], mac_q[$], wb_q[$], done_q[$];

  always @(posedge clk) cnt <= cnt + 1;

  // seq_acc model: valid L cycles after accept, ready low for bp_len cycles
  assign qracc_ready_i = (bp_seen >= bp_len);
  assign qracc_valid_i = (lat_cnt == 1);

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lat_cnt <= 0;
      bp_seen <= 0;
    end else begin
      if (mac_valid_o && qracc_ready_i) lat_cnt <= lat;
      else if (lat_cnt != 0) lat_cnt <= lat_cnt - 1;
      if (mac_valid_o) bp_seen <= qracc_ready_i ? 0 : bp_seen + 1;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic bad(string name, logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%h required=none", name, act);
  endtask

  task automatic cmp_ev(string name, ev_t e, logic [31:0] act, int rel);
    chk({name, "_val"}, act, e.val);
    if (e.cyc >= 0) chk({name, "_cyc"}, rel, e.cyc);
  endtask

  always @(negedge clk) begin
    int  rel;
    ev_t e;
    rel = cnt - start_cnt;
    if (nrst) begin
      if (busy_o) busy_cnt++;
      if (mac_valid_o && qracc_ready_i) acc_cnt++;
      if (done_o) done_cnt++;
      if (buf_rd_en_o) begin
        if (rd_q.size() == 0) bad("rd_unexpected", buf_rd_addr_o);
        else begin e = rd_q.pop_front(); cmp_ev("rd", e, buf_rd_addr_o, rel); end
      end
      if (fl_wr_en_o) begin
        if (fl_q.size() == 0) bad("fl_unexpected", fl_addr_o);
        else begin e = fl_q.pop_front(); cmp_ev("fl", e, fl_addr_o, rel); end
      end
      if (mac_valid_o) begin
        if (mac_q.size() == 0) bad("mac_unexpected", 32'd1);
        else begin e = mac_q.pop_front(); cmp_ev("mac", e, 32'd0, rel); end
      end
      if (wb_en_o) begin
        if (wb_q.size() == 0) bad("wb_unexpected", wb_addr_o);
        else begin e = wb_q.pop_front(); cmp_ev("wb", e, wb_addr_o, rel); end
      end
      if (done_o) begin
        if (done_q.size() == 0) bad("done_unexpected", 32'd1);
        else begin e = done_q.pop_front(); cmp_ev("done", e, 32'd0, rel); end
      end
    end
  end

  task automatic run(logic [31:0] rb, logic [31:0] wb, logic [31:0] rs,
                     logic [31:0] ws, logic [15:0] w, logic [15:0] n);
    @(negedge clk);
    cfg_rd_base_i    = rb;
    cfg_wr_base_i    = wb;
    cfg_rd_stride_i  = rs;
    cfg_wr_stride_i  = ws;
    cfg_words_i      = w;
    cfg_num_pixels_i = n;
    start_i   = 1'b1;
    start_cnt = cnt;
    busy_cnt  = 0;
    acc_cnt   = 0;
    done_cnt  = 0;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_drain(string name);
    int n;
    n = 0;
    while ((rd_q.size() + fl_q.size() + mac_q.size() + wb_q.size() +
            done_q.size() != 0 || busy_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) bad({name, "_timeout"}, n);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cnt);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_rd_en", buf_rd_en_o, 0);
    chk("rst_done", done_o, 0);
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_idle_busy", busy_o, 0);
    chk("rst_pixel", pixel_o, 0);
    chk("rst_wb", wb_en_o, 0);

    // single pixel W=2 N=1 L=4
    lat = 4; bp_len = 0;
    rd_q.push_back('{1, 32'h100});
    rd_q.push_back('{2, 32'h120});
    fl_q.push_back('{2, 32'd0});
    fl_q.push_back('{3, 32'd1});
    mac_q.push_back('{4, 32'd0});
    wb_q.push_back('{9, 32'h40});
    done_q.push_back('{10, 32'd0});
    run(32'h100, 32'h40, 32'h0, 32'h0, 16'd2, 16'd1);
    wait_drain("single");
    chk("single_busy_cycles", busy_cnt, 10);

    // three pixels W=1 L=2, 6 cycles per pixel
    lat = 2;
    for (int p = 0; p < 3; p++) begin
      rd_q.push_back('{1 + 6*p, 32'h100 + 32'h20*p});
      fl_q.push_back('{2 + 6*p, 32'd0});
      mac_q.push_back('{3 + 6*p, 32'd0});
      wb_q.push_back('{6 + 6*p, 32'h40 + 32'h8*p});
    end
    done_q.push_back('{19, 32'd0});
    run(32'h100, 32'h40, 32'h20, 32'h8, 16'd1, 16'd3);
    wait_drain("multi");
    chk("multi_done_count", done_cnt, 1);

    // backpressure: ready low 5 cycles per MAC, N=2 W=1 L=1
    lat = 1; bp_len = 5;
    for (int p = 0; p < 2; p++) begin
      rd_q.push_back('{1 + 10*p, 32'h500 + 32'h40*p});
      fl_q.push_back('{2 + 10*p, 32'd0});
      for (int c = 3; c <= 8; c++) mac_q.push_back('{c + 10*p, 32'd0});
      wb_q.push_back('{10 + 10*p, 32'h80 + 32'h4*p});
    end
    done_q.push_back('{21, 32'd0});
    run(32'h500, 32'h80, 32'h40, 32'h4, 16'd1, 16'd2);
    wait_drain("bp");
    chk("bp_accepts", acc_cnt, 2);
    bp_len = 0;

    // zero pixels
    done_q.push_back('{-1, 32'd0});
    run(32'h100, 32'h40, 32'h20, 32'h8, 16'd1, 16'd0);
    wait_drain("zero");
    chk("zero_busy_cycles", busy_cnt, 1);
    chk("zero_done_count", done_cnt, 1);

    // abort during MAC_WAIT of pixel 1 of 3 (W=1 L=4, 8 cycles per pixel)
    lat = 4;
    for (int p = 0; p < 2; p++) begin
      rd_q.push_back('{1 + 8*p, 32'h100 + 32'h20*p});
      fl_q.push_back('{2 + 8*p, 32'd0});
      mac_q.push_back('{3 + 8*p, 32'd0});
    end
    wb_q.push_back('{8, 32'h40});
    run(32'h100, 32'h40, 32'h20, 32'h8, 16'd1, 16'd3);
    while (cnt - start_cnt < 13) @(negedge clk);
    clear_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    start_i = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_mac", mac_valid_o, 0);
    chk("abort_pixel", pixel_o, 0);
    repeat (8) @(negedge clk);
    chk("abort_done_count", done_cnt, 0);
    chk("abort_q_left", rd_q.size() + mac_q.size() + wb_q.size(), 0);
    rd_q.push_back('{1, 32'h700});
    fl_q.push_back('{2, 32'd0});
    mac_q.push_back('{3, 32'd0});
    wb_q.push_back('{8, 32'h900});
    done_q.push_back('{9, 32'd0});
    run(32'h700, 32'h900, 32'h0, 32'h0, 16'd1, 16'd1);
    wait_drain("after_abort");

    // async reset in FETCH (W=4)
    rd_q.push_back('{1, 32'h300});
    rd_q.push_back('{2, 32'h320});
    fl_q.push_back('{2, 32'd0});
    run(32'h300, 32'h0, 32'h0, 32'h0, 16'd4, 16'd1);
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("arst_rd_en", buf_rd_en_o, 0);
    chk("arst_rd_addr", buf_rd_addr_o, 0);
    chk("arst_fl_wr", fl_wr_en_o, 0);
    chk("arst_busy", busy_o, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("arst_idle", busy_o, 0);
    chk("arst_q_left", rd_q.size() + fl_q.size(), 0);

    // address wrap-around, W=2 N=1 L=1
    lat = 1;
    rd_q.push_back('{1, 32'hFFFF_FFF0});
    rd_q.push_back('{2, 32'h0000_0010});
    fl_q.push_back('{2, 32'd0});
    fl_q.push_back('{3, 32'd1});
    mac_q.push_back('{4, 32'd0});
    wb_q.push_back('{6, 32'h200});
    done_q.push_back('{7, 32'd0});
    run(32'hFFFF_FFF0, 32'h200, 32'h0, 32'h0, 16'd2, 16'd1);
    wait_drain("wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
